// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: ISA opcodes, control-word layout
// and microstep encodings.
package cpu_pkg;

   localparam int STEP_MAX = 4;
   localparam int STEP_W   = 3;

   typedef logic [STEP_W-1:0] step_t;

   localparam step_t T0 = 3'd0;
   localparam step_t T1 = 3'd1;
   localparam step_t T2 = 3'd2;
   localparam step_t T3 = 3'd3;
   localparam step_t T4 = step_t'(STEP_MAX);

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_t;

   // Field order fixes the bit layout: hlt is bit 15, fi is bit 0.
   typedef struct packed {
      logic hlt;
      logic mi;
      logic ri;
      logic ro;
      logic io;
      logic ii;
      logic ai;
      logic ao;
      logic eo;
      logic su;
      logic bi;
      logic oi;
      logic ce;
      logic co;
      logic j;
      logic fi;
   } ctrl_t;

   localparam ctrl_t CTRL_HLT_ONLY = '{hlt: 1'b1, default: 1'b0};

   function automatic logic is_alu_op(input opcode_t op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode decode: control word and end-of-instruction flag
// for the current opcode, microstep and ALU flags.
module microcode_rom
   import cpu_pkg::*;
(
   input  logic [3:0]  opcode_i,
   input  step_t       step_i,
   input  logic        flag_carry_i,
   input  logic        flag_zero_i,
   output ctrl_t       word_o,
   output logic        last_step_o
);

   opcode_t op;
   assign op = opcode_t'(opcode_i);

   // NOTE: every output gets a default before the case so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      word_o      = '0;
      last_step_o = 1'b0;
      case (step_i)
         T0: begin
            word_o.co = 1'b1;
            word_o.mi = 1'b1;
         end
         T1: begin
            word_o.ro = 1'b1;
            word_o.ii = 1'b1;
            word_o.ce = 1'b1;
         end
         T2: begin
            last_step_o = 1'b1;
            case (op)
               OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                  word_o.io   = 1'b1;
                  word_o.mi   = 1'b1;
                  last_step_o = 1'b0;
               end
               OP_LDI: begin
                  word_o.io = 1'b1;
                  word_o.ai = 1'b1;
               end
               OP_JMP: begin
                  word_o.io = 1'b1;
                  word_o.j  = 1'b1;
               end
               // Conditional jumps look at the live flags during T2.
               OP_JC: begin
                  word_o.io = flag_carry_i;
                  word_o.j  = flag_carry_i;
               end
               OP_JZ: begin
                  word_o.io = flag_zero_i;
                  word_o.j  = flag_zero_i;
               end
               OP_OUT: begin
                  word_o.ao = 1'b1;
                  word_o.oi = 1'b1;
               end
               OP_HLT: begin
                  word_o.hlt = 1'b1;
               end
               default: ;
            endcase
         end
         T3: begin
            last_step_o = 1'b1;
            case (op)
               OP_LDA: begin
                  word_o.ro = 1'b1;
                  word_o.ai = 1'b1;
               end
               OP_STA: begin
                  word_o.ao = 1'b1;
                  word_o.ri = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  word_o.ro   = 1'b1;
                  word_o.bi   = 1'b1;
                  last_step_o = 1'b0;
               end
               default: ;
            endcase
         end
         T4: begin
            last_step_o = 1'b1;
            if (is_alu_op(op)) begin
               word_o.eo = 1'b1;
               word_o.ai = 1'b1;
               word_o.fi = 1'b1;
               word_o.su = (op == OP_SUB);
            end
         end
         // Unreachable step codes emit nothing and fall back to T0.
         default: last_step_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Microcoded control unit: owns the microstep counter and sticky halt state,
// and drives the control word from the microcode ROM.
module control_unit
   import cpu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  opcode,
   input  logic        flag_carry,
   input  logic        flag_zero,
   output ctrl_t       ctrl,
   output logic [2:0]  step,
   output logic        halted
);

   step_t step_q, step_d;
   logic  halted_q, halted_d;
   ctrl_t rom_word;
   logic  rom_last;

   microcode_rom u_rom (
      .opcode_i     (opcode),
      .step_i       (step_q),
      .flag_carry_i (flag_carry),
      .flag_zero_i  (flag_zero),
      .word_o       (rom_word),
      .last_step_o  (rom_last)
   );

   // The ROM only raises hlt at T2 of HLT, so it doubles as the halt request.
   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (halted_q) begin
         step_d = step_q;
      end else if (rom_word.hlt) begin
         halted_d = 1'b1;
      end else if (rom_last || (step_q >= T4)) begin
         step_d = T0;
      end else begin
         step_d = step_q + 3'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   assign ctrl   = halted_q ? CTRL_HLT_ONLY : rom_word;
   assign step   = step_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table of per-step vectors plus
// hand-written halt, reset and flag-timing sequences.
module tb_control_unit;
   import cpu_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  opcode;
   logic        flag_carry;
   logic        flag_zero;
   ctrl_t       ctrl;
   logic [2:0]  step;
   logic        halted;

   int total = 0;
   int bad   = 0;

   // Bits: hlt15 mi14 ri13 ro12 io11 ii10 ai9 ao8 eo7 su6 bi5 oi4 ce3 co2 j1 fi0
   localparam logic [15:0] W_F0    = 16'h4004; // co,mi
   localparam logic [15:0] W_F1    = 16'h1408; // ro,ii,ce
   localparam logic [15:0] W_IO_MI = 16'h4800;
   localparam logic [15:0] W_RO_AI = 16'h1200;
   localparam logic [15:0] W_RO_BI = 16'h1020;
   localparam logic [15:0] W_ADD4  = 16'h0281; // eo,ai,fi
   localparam logic [15:0] W_SUB4  = 16'h02C1; // eo,ai,fi,su
   localparam logic [15:0] W_AO_RI = 16'h2100;
   localparam logic [15:0] W_IO_AI = 16'h0A00;
   localparam logic [15:0] W_IO_J  = 16'h0802;
   localparam logic [15:0] W_AO_OI = 16'h0110;
   localparam logic [15:0] W_HLT   = 16'h8000;
   localparam logic [15:0] W_ZERO  = 16'h0000;

   typedef struct {
      logic [3:0]  op;
      logic        fc;
      logic        fz;
      logic [2:0]  exp_step;
      logic [15:0] exp_ctrl;
   } vec_t;

   vec_t vecs[$];

   control_unit dut (
      .clock      (clock),
      .reset      (reset),
      .opcode     (opcode),
      .flag_carry (flag_carry),
      .flag_zero  (flag_zero),
      .ctrl       (ctrl),
      .step       (step),
      .halted     (halted)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // One instruction = fetch T0/T1 plus execute steps T2..last.
   task automatic add_instr(input logic [3:0] op, input logic fc, input logic fz,
                            input int last, input logic [15:0] w2,
                            input logic [15:0] w3, input logic [15:0] w4);
      logic [15:0] ws [5];
      ws = '{W_F0, W_F1, w2, w3, w4};
      for (int s = 0; s <= last; s++)
         vecs.push_back('{op, fc, fz, 3'(s), ws[s]});
   endtask

   initial begin
      reset      = 1'b1;
      opcode     = 4'h0;
      flag_carry = 1'b0;
      flag_zero  = 1'b0;
      #1;
      check("reset step", 16'(step), 16'd0);
      check("reset halted", 16'(halted), 16'd0);
      check("reset ctrl", ctrl, W_F0);
      @(negedge clock);
      reset = 1'b0;

      add_instr(4'h1, 1'b0, 1'b0, 3, W_IO_MI, W_RO_AI, W_ZERO);
      add_instr(4'h2, 1'b0, 1'b0, 4, W_IO_MI, W_RO_BI, W_ADD4);
      add_instr(4'h3, 1'b1, 1'b1, 4, W_IO_MI, W_RO_BI, W_SUB4);
      add_instr(4'h4, 1'b0, 1'b0, 3, W_IO_MI, W_AO_RI, W_ZERO);
      add_instr(4'h5, 1'b0, 1'b0, 2, W_IO_AI, W_ZERO, W_ZERO);
      add_instr(4'h6, 1'b0, 1'b0, 2, W_IO_J,  W_ZERO, W_ZERO);
      add_instr(4'h7, 1'b0, 1'b1, 2, W_ZERO,  W_ZERO, W_ZERO);
      add_instr(4'h7, 1'b1, 1'b0, 2, W_IO_J,  W_ZERO, W_ZERO);
      add_instr(4'h8, 1'b0, 1'b1, 2, W_IO_J,  W_ZERO, W_ZERO);
      add_instr(4'h8, 1'b1, 1'b0, 2, W_ZERO,  W_ZERO, W_ZERO);
      add_instr(4'hE, 1'b0, 1'b0, 2, W_AO_OI, W_ZERO, W_ZERO);
      add_instr(4'h0, 1'b1, 1'b1, 2, W_ZERO,  W_ZERO, W_ZERO);
      add_instr(4'hA, 1'b0, 1'b0, 2, W_ZERO,  W_ZERO, W_ZERO);
      add_instr(4'h9, 1'b1, 1'b0, 2, W_ZERO,  W_ZERO, W_ZERO);
      add_instr(4'hD, 1'b0, 1'b1, 2, W_ZERO,  W_ZERO, W_ZERO);

      for (int i = 0; i < vecs.size(); i++) begin
         opcode     = vecs[i].op;
         flag_carry = vecs[i].fc;
         flag_zero  = vecs[i].fz;
         #1;
         check($sformatf("v%0d op%h step", i, vecs[i].op), 16'(step), 16'(vecs[i].exp_step));
         check($sformatf("v%0d op%h ctrl", i, vecs[i].op), ctrl, vecs[i].exp_ctrl);
         tick();
      end
      #1;
      check("table end step", 16'(step), 16'd0);

      // JC: carry rising during T2 takes effect in the same cycle.
      opcode     = 4'h7;
      flag_carry = 1'b0;
      flag_zero  = 1'b0;
      tick();
      tick();
      #1;
      check("jc live step", 16'(step), 16'd2);
      check("jc live ctrl before", ctrl, W_ZERO);
      flag_carry = 1'b1;
      #1;
      check("jc live ctrl after", ctrl, W_IO_J);
      tick();
      #1;
      check("jc live return", 16'(step), 16'd0);

      // Halt entry, freeze, override, asynchronous clear.
      opcode     = 4'hF;
      flag_carry = 1'b0;
      tick();
      tick();
      #1;
      check("hlt t2 ctrl", ctrl, W_HLT);
      check("hlt t2 halted", 16'(halted), 16'd0);
      repeat (10) tick();
      #1;
      check("halted flag", 16'(halted), 16'd1);
      check("halted step", 16'(step), 16'd2);
      check("halted ctrl", ctrl, W_HLT);
      opcode     = 4'h2;
      flag_carry = 1'b1;
      flag_zero  = 1'b1;
      #1;
      check("halted override", ctrl, W_HLT);
      reset = 1'b1;
      #1;
      check("async clr halted", 16'(halted), 16'd0);
      check("async clr step", 16'(step), 16'd0);
      check("async clr ctrl", ctrl, W_F0);
      @(negedge clock);
      reset      = 1'b0;
      opcode     = 4'h0;
      flag_carry = 1'b0;
      flag_zero  = 1'b0;
      tick();
      #1;
      check("post halt fetch", 16'(step), 16'd1);
      check("post halt ctrl", ctrl, W_F1);
      tick();
      tick();

      // Reset between edges during T3 of LDA.
      opcode = 4'h1;
      tick();
      tick();
      tick();
      #1;
      check("lda t3 step", 16'(step), 16'd3);
      check("lda t3 ctrl", ctrl, W_RO_AI);
      reset = 1'b1;
      #1;
      check("mid rst step", 16'(step), 16'd0);
      check("mid rst ctrl", ctrl, W_F0);
      tick();
      #1;
      check("rst held step", 16'(step), 16'd0);
      reset = 1'b0;
      tick();
      #1;
      check("resume t1 step", 16'(step), 16'd1);
      check("resume t1 ctrl", ctrl, W_F1);
      tick();
      tick();
      #1;
      check("resume t3 ctrl", ctrl, W_RO_AI);
      tick();
      #1;
      check("resume end step", 16'(step), 16'd0);

      // Random opcode stream (no HLT): the step counter stays in range.
      for (int i = 0; i < 100; i++) begin
         opcode     = 4'($urandom_range(0, 14));
         flag_carry = 1'($urandom_range(0, 1));
         flag_zero  = 1'($urandom_range(0, 1));
         tick();
         #1;
         check($sformatf("rand%0d step bound", i), 16'(step <= 3'd4), 16'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use reset reset, asynchronous, active-high; clock clock.
REQ-002 Port: clock  input  1  system clock, all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous active-high reset.
REQ-004 Port: opcode  input  4  instruction-register upper nibble.
REQ-005 Port: flag_carry  input  1  registered ALU carry flag.
REQ-006 Port: flag_zero  input  1  registered ALU zero flag.
REQ-007 Port: ctrl  output  16  control word of type ctrl_t: hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi.
REQ-008 Port: step  output  3  current microstep T0..T4.
REQ-009 Port: halted  output  1  sticky halt status.

Function
REQ-010 ctrl SHALL be combinational from (step, opcode, flags, halted); every bit not listed for a step SHALL be 0.
REQ-011 Fetch for every opcode: T0 = co,mi; T1 = ro,ii,ce.
REQ-012 Execute microcode: LDA(1) T2 io,mi / T3 ro,ai.
REQ-013 ADD(2): T2 io,mi / T3 ro,bi / T4 eo,ai,fi.
REQ-014 SUB(3): ADD sequence with su also asserted at T4.
REQ-015 STA(4): T2 io,mi / T3 ao,ri.
REQ-016 Single-step opcodes at T2: LDI(5) io,ai; JMP(6) io,j; OUT(E) ao,oi; HLT(F) hlt.
REQ-017 JC(7) and JZ(8): T2 io,j only if flag_carry=1 or flag_zero=1 respectively; otherwise T2 ctrl=0.
REQ-018 NOP(0) and undefined opcodes 9..D: no T2+ control; treated as NOP.
REQ-019 step SHALL advance by 1 per clock and return to T0 on the clock after the last step used by the opcode: T1 for none; T2 for LDI/JMP/JC/JZ/OUT/NOP/undefined; T3 for LDA/STA; T4 for ADD/SUB.
REQ-020 step SHALL never exceed 4; a value of 5..7 (unreachable) SHALL return to T0 on the next clock.
REQ-021 Flags for JC/JZ SHALL be sampled combinationally during T2; a flag change in T2 takes effect in that same cycle.
REQ-022 At T2 of HLT, the next clock SHALL set halted=1 and freeze step at T2.
REQ-023 While halted=1, ctrl SHALL be hlt only (all other bits 0), regardless of opcode or flags.
REQ-024 halted SHALL clear only through reset.
REQ-025 The opcode input SHALL be treated as stable from the end of T1 until the instruction ends; decode SHALL use the live value.

Reset
REQ-026 On reset assertion, step SHALL become 0 and halted SHALL become 0 immediately, without waiting for a clock edge.
REQ-027 While reset is asserted, ctrl SHALL equal the T0 word (co,mi).
REQ-028 Reset mid-instruction (any step, including halted) SHALL abandon the instruction; the first clock after deassertion SHALL move to T1.

Structure
REQ-029 A shared package (cpu_pkg) SHALL hold opcode_t (4-bit enum of the ISA values above), ctrl_t (16-bit packed struct, field order as REQ-007, hlt at MSB), and constant STEP_MAX=4.
REQ-030 Microcode decode SHALL be a combinational sub-module microcode_rom with inputs (opcode, step, flag_carry, flag_zero) and outputs (ctrl_t word, last_step flag).
REQ-031 control_unit SHALL own the step counter, the halted register, and the halted override.

Verification
REQ-032 Reset and fetch: release reset, run 2 clocks -> step 0,1; ctrl 0xxx with co,mi then ro,ii,ce; step=2 after the second clock.
REQ-033 ADD timing: opcode=2 -> T2 io,mi; T3 ro,bi; T4 eo,ai,fi with su=0; step=0 after T4. Opcode=3 -> identical, plus su=1 at T4.
REQ-034 Conditional jump: opcode=7 with flag_carry=0 -> T2 ctrl=0. With flag_carry=1 -> T2 io,j. Opcode=8 with flag_zero=1 -> io,j. All three return to T0 after T2.
REQ-035 Halt: opcode=F -> T2 hlt. Then 10 further clocks -> halted=1, step=2, ctrl=hlt only. Assert reset -> halted=0, step=0 asynchronously.
REQ-036 Reset mid-operation: assert reset during T3 of LDA between clock edges -> step=0 before the next edge, ctrl=co,mi. Deassert reset -> normal fetch resumes.
REQ-037 Undefined opcodes: opcode=0xA and opcode=0 -> no control bits at T2, return to T0 next clock; 100-cycle random opcode stream -> step never exceeds 4.
